// File: rtl/ibuf_fill_ctrl.sv
// ---------------------------------------------------------------------------
// ibuf_fill_ctrl
//
// Double-buffering fill controller for the input buffer bank array. Each bank
// address space is split into two halves by the address MSB. DDR beats are
// written into the half that the systolic-array read side is not using. A
// completed tile is handed over with a valid/release handshake, so loading
// and compute can overlap.
//
// Optional feature: define IBUF_FILL_PERF_EN to build the stall counter.
// Without it, perf_stall_cycles is tied to zero.
//
// Ports:
//   clk                single clock
//   reset              asynchronous, active-low reset
//   cfg_start          one-cycle pulse that starts a tile load (honoured only in IDLE)
//   cfg_num_beats      beats in the tile (0 = ignore start, clamped to HALF)
//   cfg_base_addr      start offset within the half
//   ddr_valid/ddr_data DDR beat input
//   ddr_ready          beat accepted when ddr_valid && ddr_ready
//   bs_write_req       per-bank write enable (all banks written together)
//   bs_write_addr      per-bank write address {half, offset}
//   bs_write_data      write data; bank b takes lane b of WRITE_WIDTH bits
//   cons_tile_valid    half selected by cons_buf_sel holds a complete tile
//   cons_buf_sel       half the consumer reads
//   cons_tile_done     consumer releases its current half
//   busy               a load is in progress (state not IDLE)
//   tile_loaded        one-cycle pulse during the commit cycle
//   perf_stall_cycles  WAIT_BUF cycles + LOAD cycles without ddr_valid
//   dbg_state          current FSM state, for observation only
//
// Handshake: a beat transfers on every rising clk edge where
// ddr_valid && ddr_ready. ddr_ready is high exactly while the FSM is in LOAD
// and does not depend on ddr_valid. cons_tile_done is honoured only while
// cons_tile_valid is high.
//
// DDR_BANDWIDTH must equal NUM_BANKS*WRITE_WIDTH.
// ---------------------------------------------------------------------------
module ibuf_fill_ctrl #(
    parameter int NUM_BANKS        = 64,
    parameter int WRITE_WIDTH      = 8,
    parameter int DDR_BANDWIDTH    = 512,
    parameter int WRITE_ADDR_WIDTH = 8,
    parameter int PERF_WIDTH       = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   cfg_start,
    input  logic [WRITE_ADDR_WIDTH-1:0]            cfg_num_beats,
    input  logic [WRITE_ADDR_WIDTH-2:0]            cfg_base_addr,
    input  logic                                   ddr_valid,
    input  logic [DDR_BANDWIDTH-1:0]               ddr_data,
    output logic                                   ddr_ready,
    output logic [NUM_BANKS-1:0]                   bs_write_req,
    output logic [NUM_BANKS*WRITE_ADDR_WIDTH-1:0]  bs_write_addr,
    output logic [DDR_BANDWIDTH-1:0]               bs_write_data,
    output logic                                   cons_tile_valid,
    output logic                                   cons_buf_sel,
    input  logic                                   cons_tile_done,
    output logic                                   busy,
    output logic                                   tile_loaded,
    output logic [PERF_WIDTH-1:0]                  perf_stall_cycles,
    output logic [1:0]                             dbg_state
);

    localparam int OFS_W = WRITE_ADDR_WIDTH - 1;
    localparam logic [WRITE_ADDR_WIDTH-1:0] HALF_N = {1'b1, {OFS_W{1'b0}}};
    localparam logic [WRITE_ADDR_WIDTH-1:0] ONE_N  = {{OFS_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUF = 2'd1,
        LOAD     = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    state_t                        state_q;
    logic                          fill_sel_q;
    logic                          cons_sel_q;
    logic [1:0]                    full_q;
    logic [1:0]                    full_d;
    logic [WRITE_ADDR_WIDTH-1:0]   cnt_q;
    logic [WRITE_ADDR_WIDTH-1:0]   num_q;
    logic [OFS_W-1:0]              base_q;
    logic                          wr_req_q;
    logic [WRITE_ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DDR_BANDWIDTH-1:0]      wr_data_q;
    logic                          tile_loaded_q;

    logic                          accept;
    logic                          last_beat;
    logic                          release_tile;
    logic [1:0]                    full_set;
    logic [1:0]                    full_clr;
    logic [WRITE_ADDR_WIDTH-1:0]   num_clamped;
    logic [OFS_W-1:0]              wr_ofs;

    assign ddr_ready    = (state_q == LOAD);
    assign accept       = ddr_valid && ddr_ready;
    assign last_beat    = (cnt_q == (num_q - ONE_N));
    assign num_clamped  = (cfg_num_beats > HALF_N) ? HALF_N : cfg_num_beats;
    // Offset arithmetic is OFS_W bits wide, so it wraps inside the half.
    assign wr_ofs       = base_q + cnt_q[OFS_W-1:0];

    assign release_tile = cons_tile_done && full_q[cons_sel_q];
    // Commit and release always target different halves, so both masks can
    // be applied in the same cycle.
    assign full_set     = (state_q == COMMIT) ? {fill_sel_q, ~fill_sel_q} : 2'b00;
    assign full_clr     = release_tile ? {cons_sel_q, ~cons_sel_q} : 2'b00;
    assign full_d       = (full_q | full_set) & ~full_clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fill_sel_q    <= 1'b0;
            cons_sel_q    <= 1'b0;
            full_q        <= 2'b00;
            cnt_q         <= '0;
            num_q         <= '0;
            base_q        <= '0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            tile_loaded_q <= 1'b0;
        end else begin
            wr_req_q      <= 1'b0;
            tile_loaded_q <= 1'b0;
            full_q        <= full_d;
            if (release_tile) begin
                cons_sel_q <= ~cons_sel_q;
            end
            case (state_q)
                IDLE: begin
                    if (cfg_start && (cfg_num_beats != '0)) begin
                        base_q  <= cfg_base_addr;
                        num_q   <= num_clamped;
                        cnt_q   <= '0;
                        state_q <= full_q[fill_sel_q] ? WAIT_BUF : LOAD;
                    end
                end
                WAIT_BUF: begin
                    if (!full_q[fill_sel_q]) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= {fill_sel_q, wr_ofs};
                        wr_data_q <= ddr_data;
                        cnt_q     <= cnt_q + ONE_N;
                        if (last_beat) begin
                            // Pulse lines up with the last write, which is
                            // the COMMIT cycle.
                            state_q       <= COMMIT;
                            tile_loaded_q <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    fill_sel_q <= ~fill_sel_q;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bs_write_req    = {NUM_BANKS{wr_req_q}};
    assign bs_write_addr   = {NUM_BANKS{wr_addr_q}};
    assign cons_tile_valid = full_q[cons_sel_q];
    assign cons_buf_sel    = cons_sel_q;
    assign busy            = (state_q != IDLE);
    assign tile_loaded     = tile_loaded_q;
    assign dbg_state       = state_q;

    // Bank b receives lane b of the registered beat.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bs_write_data[b*WRITE_WIDTH +: WRITE_WIDTH] = wr_data_q[b*WRITE_WIDTH +: WRITE_WIDTH];
    end

`ifdef IBUF_FILL_PERF_EN
    logic [PERF_WIDTH-1:0] stall_q;
    logic                  stall_cycle;

    assign stall_cycle = (state_q == WAIT_BUF) || ((state_q == LOAD) && !ddr_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if (stall_cycle && (stall_q != '1)) begin
            stall_q <= stall_q + {{(PERF_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign perf_stall_cycles = stall_q;
`else
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ibuf_fill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibuf_fill_ctrl
//
// Randomized self-checking bench for ibuf_fill_ctrl. Inputs are driven and
// outputs sampled on the falling clock edge. The reference model keeps the
// two half-buffer flags, the fill/consume pointers and the stall count as
// plain variables. Expected writes ({address, data}) are queued when a beat
// is offered in LOAD, and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_ibuf_fill_ctrl;

    localparam int NB   = 64;
    localparam int WW   = 8;
    localparam int DW   = 512;
    localparam int AW   = 8;
    localparam int PW   = 32;
    localparam int HALF = 128;

    logic                clk = 1'b0;
    logic                reset;
    logic                cfg_start;
    logic [AW-1:0]       cfg_num_beats;
    logic [AW-2:0]       cfg_base_addr;
    logic                ddr_valid;
    logic [DW-1:0]       ddr_data;
    logic                ddr_ready;
    logic [NB-1:0]       bs_write_req;
    logic [NB*AW-1:0]    bs_write_addr;
    logic [DW-1:0]       bs_write_data;
    logic                cons_tile_valid;
    logic                cons_buf_sel;
    logic                cons_tile_done;
    logic                busy;
    logic                tile_loaded;
    logic [PW-1:0]       perf_stall_cycles;
    logic [1:0]          dbg_state;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected writes: {address, data}.
    logic [AW+DW-1:0] exp_q[$];

    // Reference model.
    bit m_full[2];
    bit m_fill;
    bit m_cons;
    int m_n;
    int m_base;
    int m_stall;

    ibuf_fill_ctrl #(
        .NUM_BANKS        (NB),
        .WRITE_WIDTH      (WW),
        .DDR_BANDWIDTH    (DW),
        .WRITE_ADDR_WIDTH (AW),
        .PERF_WIDTH       (PW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_start         (cfg_start),
        .cfg_num_beats     (cfg_num_beats),
        .cfg_base_addr     (cfg_base_addr),
        .ddr_valid         (ddr_valid),
        .ddr_data          (ddr_data),
        .ddr_ready         (ddr_ready),
        .bs_write_req      (bs_write_req),
        .bs_write_addr     (bs_write_addr),
        .bs_write_data     (bs_write_data),
        .cons_tile_valid   (cons_tile_valid),
        .cons_buf_sel      (cons_buf_sel),
        .cons_tile_done    (cons_tile_done),
        .busy              (busy),
        .tile_loaded       (tile_loaded),
        .perf_stall_cycles (perf_stall_cycles),
        .dbg_state         (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_fill    = 1'b0;
        m_cons    = 1'b0;
        m_stall   = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset          = 1'b0;
        cfg_start      = 1'b0;
        ddr_valid      = 1'b0;
        cons_tile_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_tile(input int base, input int num);
        cfg_start     = 1'b1;
        cfg_num_beats = AW'(num);
        cfg_base_addr = (AW-1)'(base);
        @(negedge clk);
        cfg_start = 1'b0;
        if (num != 0) begin
            m_n    = (num > HALF) ? HALF : num;
            m_base = base;
        end
    endtask

    task automatic release_tile();
        checks++;
        if (cons_tile_valid !== m_full[m_cons] || cons_buf_sel !== m_cons) begin
            failures++;
            $display("FAIL release_pre: valid=%0b sel=%0b required valid=%0b sel=%0b",
                     cons_tile_valid, cons_buf_sel, m_full[m_cons], m_cons);
        end
        cons_tile_done = 1'b1;
        @(negedge clk);
        cons_tile_done = 1'b0;
        if (m_full[m_cons]) begin
            m_full[m_cons] = 1'b0;
            m_cons         = ~m_cons;
        end
        checks++;
        if (cons_tile_valid !== m_full[m_cons] || cons_buf_sel !== m_cons) begin
            failures++;
            $display("FAIL release_post: valid=%0b sel=%0b required valid=%0b sel=%0b",
                     cons_tile_valid, cons_buf_sel, m_full[m_cons], m_cons);
        end
    endtask

    task automatic check_perf(input string tag);
        logic [PW-1:0] exp_perf;
`ifdef IBUF_FILL_PERF_EN
        exp_perf = PW'(m_stall);
`else
        exp_perf = '0;
`endif
        checks++;
        if (perf_stall_cycles !== exp_perf) begin
            failures++;
            $display("FAIL perf_%s: got=%0d required=%0d", tag, perf_stall_cycles, exp_perf);
        end
    endtask

    // Streams the current tile; the DUT must already be in LOAD.
    task automatic stream_beats(input int gap_pct, input bit poke_start, input bit release_at_commit);
        logic [AW+DW-1:0] exp_w;
        logic [DW-1:0]    d;
        logic [AW-1:0]    ea;
        bit               pending = 1'b0;
        int               acc = 0;
        int               cyc = 0;
        forever begin
            cfg_start = 1'b0;
            if (pending) begin
                exp_w = exp_q.pop_front();
                checks++;
                if (bs_write_req !== {NB{1'b1}} || bs_write_addr !== {NB{exp_w[AW+DW-1:DW]}} ||
                    bs_write_data !== exp_w[DW-1:0]) begin
                    failures++;
                    $display("FAIL write: beat=%0d req=%h addr=%0d required addr=%0d data_ok=%0b",
                             acc - 1, bs_write_req, bs_write_addr[AW-1:0], exp_w[AW+DW-1:DW],
                             bs_write_data === exp_w[DW-1:0]);
                end
            end else begin
                checks++;
                if (bs_write_req !== '0) begin
                    failures++;
                    $display("FAIL idle_write: req=%h required 0", bs_write_req);
                end
            end
            if (acc == m_n) break;
            checks++;
            if (ddr_ready !== 1'b1 || busy !== 1'b1 || tile_loaded !== 1'b0) begin
                failures++;
                $display("FAIL load_state: ready=%0b busy=%0b tile_loaded=%0b required 1 1 0",
                         ddr_ready, busy, tile_loaded);
            end
            if (poke_start && cyc == 2) begin
                cfg_start     = 1'b1;
                cfg_num_beats = AW'(1);
                cfg_base_addr = '0;
            end
            for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
            ddr_data = d;
            if ($urandom_range(0, 99) >= gap_pct) begin
                ea = AW'(int'(m_fill) * HALF + (m_base + acc) % HALF);
                ddr_valid = 1'b1;
                exp_q.push_back({ea, d});
                acc++;
                pending = 1'b1;
            end else begin
                ddr_valid = 1'b0;
                pending   = 1'b0;
                m_stall++;
            end
            @(negedge clk);
            cyc++;
        end
        // Commit cycle: last write is visible, tile_loaded pulses.
        ddr_valid = 1'b0;
        checks++;
        if (tile_loaded !== 1'b1 || ddr_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL commit: tile_loaded=%0b ready=%0b busy=%0b required 1 0 1",
                     tile_loaded, ddr_ready, busy);
        end
        if (release_at_commit) cons_tile_done = 1'b1;
        @(negedge clk);
        cons_tile_done = 1'b0;
        if (release_at_commit && m_full[m_cons]) begin
            m_full[m_cons] = 1'b0;
            m_cons         = ~m_cons;
        end
        m_full[m_fill] = 1'b1;
        m_fill         = ~m_fill;
        checks++;
        if (bs_write_req !== '0 || tile_loaded !== 1'b0 || busy !== 1'b0 || ddr_ready !== 1'b0 ||
            cons_tile_valid !== m_full[m_cons] || cons_buf_sel !== m_cons || exp_q.size() != 0) begin
            failures++;
            $display("FAIL after_commit: req=%h tl=%0b busy=%0b ready=%0b valid=%0b sel=%0b required valid=%0b sel=%0b",
                     bs_write_req, tile_loaded, busy, ddr_ready, cons_tile_valid, cons_buf_sel,
                     m_full[m_cons], m_cons);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset          = 1'b0;
        cfg_start      = 1'b0;
        cfg_num_beats  = '0;
        cfg_base_addr  = '0;
        ddr_valid      = 1'b0;
        ddr_data       = '0;
        cons_tile_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ddr_ready !== 1'b0 || bs_write_req !== '0 || bs_write_addr !== '0 || bs_write_data !== '0 ||
            cons_tile_valid !== 1'b0 || cons_buf_sel !== 1'b0 || busy !== 1'b0 || tile_loaded !== 1'b0 ||
            perf_stall_cycles !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%0b req=%h valid=%0b sel=%0b busy=%0b perf=%0d required all 0",
                     ddr_ready, bs_write_req, cons_tile_valid, cons_buf_sel, busy, perf_stall_cycles);
        end
        reset = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_tile();
        start_tile(0, 4);
        stream_beats(0, 1'b0, 1'b0);
        check_perf("single");
    endtask

    task automatic test_wrap();
        start_tile(126, 4);
        stream_beats(0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        localparam int K = 4;
        start_tile(10, 3);
        for (int k = 0; k < K; k++) begin
            checks++;
            if (busy !== 1'b1 || ddr_ready !== 1'b0) begin
                failures++;
                $display("FAIL wait_buf: busy=%0b ready=%0b required 1 0", busy, ddr_ready);
            end
            if (k == K - 1) cons_tile_done = 1'b1;
            @(negedge clk);
        end
        cons_tile_done = 1'b0;
        m_full[m_cons] = 1'b0;
        m_cons         = ~m_cons;
        checks++;
        if (busy !== 1'b1 || ddr_ready !== 1'b0 || cons_buf_sel !== 1'b1 || cons_tile_valid !== 1'b1) begin
            failures++;
            $display("FAIL wait_release: busy=%0b ready=%0b sel=%0b valid=%0b required 1 0 1 1",
                     busy, ddr_ready, cons_buf_sel, cons_tile_valid);
        end
        @(negedge clk);
        m_stall += K + 1;
        check_perf("wait");
        stream_beats(10, 1'b0, 1'b0);
        check_perf("backpressure");
        release_tile();
        release_tile();
    endtask

    task automatic test_edge_configs();
        start_tile(7, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0 || ddr_ready !== 1'b0 || cons_tile_valid !== m_full[m_cons]) begin
                failures++;
                $display("FAIL zero_beats: busy=%0b ready=%0b valid=%0b required 0 0 %0b",
                         busy, ddr_ready, cons_tile_valid, m_full[m_cons]);
            end
            @(negedge clk);
        end
        // 200 beats requested: clamped to one half, with a stray start mid-load.
        start_tile(5, 200);
        stream_beats(15, 1'b1, 1'b0);
        check_perf("edge");
        release_tile();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        start_tile(0, 2);
        stream_beats(0, 1'b0, 1'b0);
        start_tile(40, 3);
        stream_beats(0, 1'b0, 1'b1);
        checks++;
        if (cons_buf_sel !== 1'b1 || cons_tile_valid !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous: sel=%0b valid=%0b required 1 1", cons_buf_sel, cons_tile_valid);
        end
        // Releasing half 1 must expose half 0 as empty.
        release_tile();
    endtask

    task automatic test_random();
        int base;
        int num;
        for (int t = 0; t < 8; t++) begin
            if (m_full[m_fill] || $urandom_range(0, 1) == 1) release_tile();
            base = $urandom_range(0, HALF - 1);
            num  = $urandom_range(1, 40);
            start_tile(base, num);
            stream_beats($urandom_range(0, 40), 1'b0, 1'b0);
        end
        check_perf("random");
    endtask

    task automatic test_reset_mid_load();
        logic [AW+DW-1:0] exp_w;
        logic [DW-1:0]    d;
        apply_reset();
        start_tile(20, 8);
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
            ddr_valid = 1'b1;
            ddr_data  = d;
            exp_q.push_back({AW'(20 + b), d});
            @(negedge clk);
            exp_w = exp_q.pop_front();
            checks++;
            if (bs_write_req !== {NB{1'b1}} || bs_write_addr[AW-1:0] !== exp_w[AW+DW-1:DW] ||
                bs_write_data !== exp_w[DW-1:0]) begin
                failures++;
                $display("FAIL pre_reset_write: beat=%0d addr=%0d required %0d", b,
                         bs_write_addr[AW-1:0], exp_w[AW+DW-1:DW]);
            end
        end
        ddr_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ddr_ready !== 1'b0 || bs_write_req !== '0 || bs_write_addr !== '0 || bs_write_data !== '0 ||
            cons_tile_valid !== 1'b0 || cons_buf_sel !== 1'b0 || busy !== 1'b0 || tile_loaded !== 1'b0 ||
            perf_stall_cycles !== '0) begin
            failures++;
            $display("FAIL mid_reset: ready=%0b req=%h addr=%0d busy=%0b required all 0",
                     ddr_ready, bs_write_req, bs_write_addr[AW-1:0], busy);
        end
        @(negedge clk);
        checks++;
        if (bs_write_req !== '0 || busy !== 1'b0 || ddr_ready !== 1'b0) begin
            failures++;
            $display("FAIL dropped_beat: req=%h busy=%0b ready=%0b required 0 0 0",
                     bs_write_req, busy, ddr_ready);
        end
        ddr_valid = 1'b0;
        reset     = 1'b1;
        model_reset();
        @(negedge clk);
        start_tile(20, 3);
        stream_beats(0, 1'b0, 1'b0);
        check_perf("after_reset");
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        test_reset();
        test_single_tile();
        test_wrap();
        test_backpressure();
        test_edge_configs();
        test_simultaneous();
        test_random();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
